// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1-style framing with mid-bit sampling and start-glitch rejection.
// Optional macro UART_RX_FERR_EN adds the rx_ferr framing-error strobe.
`timescale 1ns/1ps

module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    output logic                  tick,
    output logic [DATA_WIDTH-1:0] rx_out,
`ifdef UART_RX_FERR_EN
    output logic                  rx_ferr,
`endif
    output logic                  rx_dv
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = (OVERSAMPLE > 16) ? $clog2(OVERSAMPLE) : 4;
    localparam int NW      = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [CW-1:0] div_cnt;
    logic          sync_q1;
    logic          line;

    state_t                state, state_next;
    logic [SW-1:0]         s_cnt, s_next;
    logic [NW-1:0]         n_cnt, n_next;
    logic [DATA_WIDTH-1:0] shreg, sh_next;
    logic                  break_wait, bw_next;
    logic                  load, dv_next;
`ifdef UART_RX_FERR_EN
    logic                  ferr_next;
`endif

    // Free-running oversample divider; tick is the last count of each period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == CW'(DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = !rst && (div_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            line    <= 1'b1;
        end else begin
            sync_q1 <= rx_in;
            line    <= sync_q1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            s_cnt      <= '0;
            n_cnt      <= '0;
            shreg      <= '0;
            break_wait <= 1'b0;
            rx_out     <= '0;
            rx_dv      <= 1'b0;
`ifdef UART_RX_FERR_EN
            rx_ferr    <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            s_cnt      <= s_next;
            n_cnt      <= n_next;
            shreg      <= sh_next;
            break_wait <= bw_next;
            rx_dv      <= dv_next;
            if (load) begin
                rx_out <= shreg;
            end
`ifdef UART_RX_FERR_EN
            rx_ferr    <= ferr_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        s_next     = s_cnt;
        n_next     = n_cnt;
        sh_next    = shreg;
        bw_next    = break_wait;
        load       = 1'b0;
        dv_next    = 1'b0;
`ifdef UART_RX_FERR_EN
        ferr_next  = 1'b0;
`endif
        case (state)
            IDLE: begin
                // After a framing error the line may still be low (break);
                // only a return to 1 re-arms start detection.
                if (break_wait) begin
                    if (line) begin
                        bw_next = 1'b0;
                    end
                end else if (!line) begin
                    s_next     = '0;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt == SW'(OVERSAMPLE / 2 - 1)) begin
                        if (!line) begin
                            s_next     = '0;
                            n_next     = '0;
                            state_next = DATA;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt == SW'(OVERSAMPLE - 1)) begin
                        s_next  = '0;
                        sh_next = {line, shreg[DATA_WIDTH-1:1]};
                        if (n_cnt == NW'(DATA_WIDTH - 1)) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_cnt + 1'b1;
                        end
                    end else begin
                        s_next = s_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_cnt == SW'(OVERSAMPLE - 1)) begin
                        if (line) begin
                            load    = 1'b1;
                            dv_next = 1'b1;
                        end else begin
                            bw_next = 1'b1;
`ifdef UART_RX_FERR_EN
                            ferr_next = 1'b1;
`endif
                        end
                        state_next = IDLE;
                    end else begin
                        s_next = s_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scoreboard queue of expected bytes and stop-bit midpoints.
`timescale 1ns/1ps

module tb_uart_rx;
    localparam int W   = 8;
    localparam int BIT = 8680;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_in = 1'b1;
    logic         tick;
    logic [W-1:0] rx_out;
    logic         rx_dv;
`ifdef UART_RX_FERR_EN
    logic         rx_ferr;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int dv_cnt = 0;
    int ferr_cnt = 0;
    logic prev_dv = 1'b0;

    logic [W-1:0] exp_q[$];
    realtime      exp_t[$];

    // clock / reset
    always #10 clk = ~clk;

    uart_rx dut (
        .clk    (clk),
        .rst    (rst),
        .rx_in  (rx_in),
        .tick   (tick),
        .rx_out (rx_out),
`ifdef UART_RX_FERR_EN
        .rx_ferr(rx_ferr),
`endif
        .rx_dv  (rx_dv)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver: one frame LSB first; optional low hold after the stop bit
    task automatic send_frame(input logic [W-1:0] d, input logic stop, input bit push, input int hold_bits);
        rx_in = 1'b0;
        #(BIT);
        for (int i = 0; i < W; i++) begin
            rx_in = d[i];
            #(BIT);
        end
        if (push) begin
            exp_q.push_back(d);
            exp_t.push_back($realtime + BIT / 2);
        end
        rx_in = stop;
        #(BIT);
        if (hold_bits > 0) begin
            rx_in = 1'b0;
            #(BIT * hold_bits);
        end
        rx_in = 1'b1;
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (rx_dv) begin
            dv_cnt++;
            check("dv_single", {31'd0, prev_dv}, 32'd0);
            check("dv_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                logic [W-1:0] e;
                realtime t, dt;
                e  = exp_q.pop_front();
                t  = exp_t.pop_front();
                dt = $realtime - t;
                check("rx_out", {24'd0, rx_out}, {24'd0, e});
                check("dv_timing", {31'd0, (dt <= BIT) && (dt >= -BIT)}, 32'd1);
            end
        end
`ifdef UART_RX_FERR_EN
        if (rx_ferr) ferr_cnt++;
`endif
        prev_dv = rx_dv;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_out", {24'd0, rx_out}, 32'd0);
        check("reset_dv", {31'd0, rx_dv}, 32'd0);
        check("reset_tick", {31'd0, tick}, 32'd0);
        check("reset_state", 32'(dut.state), 32'd0);
        rst = 1'b0;

        // tick period and width
        n = 0;
        while (!tick && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tick_seen", {31'd0, tick}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("tick_width", {31'd0, tick}, 32'd0);
            n = 1;
            while (!tick && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("tick_period", n, 32'd27);
        end

        #(BIT * 2);
        send_frame(8'h55, 1'b1, 1'b1, 0);
        #100000;
        send_frame(8'hF0, 1'b1, 1'b1, 0);
        #100000;
        send_frame(8'h3C, 1'b1, 1'b1, 0);
        #10000;

        // short low glitch on idle line
        rx_in = 1'b0;
        #2000;
        rx_in = 1'b1;
        #(BIT * 2);
        check("glitch_idle", 32'(dut.state), 32'd0);
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        #10000;

        // framing error followed by a held-low line
        send_frame(8'h3C, 1'b0, 1'b0, 3);
        #10000;
        check("ferr_rx_out", {24'd0, rx_out}, 32'h0000_00A5);
        check("ferr_state", 32'(dut.state), 32'd0);

        // reset during bit 4 of 0xF0
        fork
            send_frame(8'hF0, 1'b1, 1'b0, 0);
            begin
                #(BIT * 11 / 2);
                rst = 1'b1;
                #200;
                rst = 1'b0;
            end
        join
        check("rst_rx_out", {24'd0, rx_out}, 32'd0);
        #10000;
        send_frame(8'h55, 1'b1, 1'b1, 0);
        #10000;

        // back-to-back frames
        send_frame(8'h00, 1'b1, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 1'b1, 0);
        #10000;

        check("queue_empty", exp_q.size(), 32'd0);
        check("dv_count", dv_cnt, 32'd7);
`ifdef UART_RX_FERR_EN
        check("ferr_count", ferr_cnt, 32'd1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
